// File: rtl/osc_bank.sv
// Time-multiplexed bank of phase-accumulator oscillators (sine/saw/square/triangle) sharing one
// iterative CORDIC. Define OSC_BANK_HARD_SYNC_EN to add the per-channel phase_sync reset input.
module osc_bank #(
   parameter int NUM_CH       = 4,
   parameter int PHASE_W      = 24,
   parameter int OUT_W        = 16,
   parameter int CORDIC_ITERS = 16
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      sample_tick,
   input  logic [NUM_CH*PHASE_W-1:0] delta_phase,
   input  logic [NUM_CH*2-1:0]       wave_sel,
`ifdef OSC_BANK_HARD_SYNC_EN
   input  logic [NUM_CH-1:0]         phase_sync,
`endif
   output logic [NUM_CH*OUT_W-1:0]   ch_sample,
   output logic                      sample_valid,
   output logic                      busy
);
   localparam int CHW  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
   localparam int ITW  = $clog2(CORDIC_ITERS);
   localparam int FRAC = 2;
   localparam int XW   = OUT_W + 4;
   localparam int FS   = 2**(OUT_W-1) - 1;

   // x0 = round(FS * K * 2^FRAC), K = 0.6072529350 held as a 0.32 fixed-point constant
   localparam logic [63:0] X0_64 = (64'(FS) * 64'd2608131496 + (64'd1 << (31 - FRAC))) >> (32 - FRAC);
   localparam logic signed [XW-1:0]    X0    = X0_64[XW-1:0];
   localparam logic signed [XW-1:0]    RND_X = XW'(2**(FRAC-1));
   localparam logic signed [XW-1:0]    FS_X  = XW'(FS);
   localparam logic signed [XW-1:0]    NFS_X = XW'(-FS);
   localparam logic [OUT_W-1:0]        FS_O  = OUT_W'(FS);
   localparam logic [OUT_W-1:0]        NFS_O = OUT_W'(-FS);
   localparam logic [PHASE_W-1:0]      HALF  = PHASE_W'(1) << (PHASE_W - 1);

   // atan(2^-i) in units of 2^-32 turn; rescaled to PHASE_W below (PHASE_W <= 32, ITERS <= 32)
   localparam logic [31:0] ATAN32 [32] = '{
      32'h20000000, 32'h12E4051E, 32'h09FB385B, 32'h051111D4, 32'h028B0D43, 32'h0145D7E1,
      32'h00A2F61E, 32'h00517C55, 32'h0028BE53, 32'h00145F2F, 32'h000A2F98, 32'h000517CC,
      32'h00028BE6, 32'h000145F3, 32'h0000A2FA, 32'h0000517D, 32'h000028BE, 32'h0000145F,
      32'h00000A30, 32'h00000518, 32'h0000028C, 32'h00000146, 32'h000000A3, 32'h00000051,
      32'h00000029, 32'h00000014, 32'h0000000A, 32'h00000005, 32'h00000003, 32'h00000001,
      32'h00000001, 32'h00000000};

   typedef enum logic [2:0] {S_IDLE, S_LOAD, S_ROT, S_STORE, S_DONE} state_t;

   state_t                     state_q;
   logic [CHW-1:0]             ch_q;
   logic [ITW-1:0]             iter_q;
   logic [PHASE_W-1:0]         phase_q  [NUM_CH];
   logic [PHASE_W-1:0]         delta_q  [NUM_CH];
   logic [1:0]                 wsel_q   [NUM_CH];
   logic [OUT_W-1:0]           shadow_q [NUM_CH];
   logic [OUT_W-1:0]           out_q    [NUM_CH];
   logic signed [XW-1:0]       x_q, y_q;
   logic signed [PHASE_W-1:0]  z_q;
   logic                       valid_q, busy_q;

   logic [PHASE_W-1:0]         atan_tab [CORDIC_ITERS];
   logic [PHASE_W-1:0]         delta_in [NUM_CH];
   logic [1:0]                 wsel_in  [NUM_CH];

   genvar gi;
   generate
      for (gi = 0; gi < CORDIC_ITERS; gi++) begin : g_atan
         localparam logic [63:0] A64 = ((64'(ATAN32[gi]) << PHASE_W) + 64'h8000_0000) >> 32;
         assign atan_tab[gi] = A64[PHASE_W-1:0];
      end
      for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
         assign delta_in[gi]                    = delta_phase[gi*PHASE_W +: PHASE_W];
         assign wsel_in[gi]                     = wave_sel[gi*2 +: 2];
         assign ch_sample[gi*OUT_W +: OUT_W]    = out_q[gi];
      end
   endgenerate

   assign sample_valid = valid_q;
   assign busy         = busy_q;

   // Datapath for the channel currently selected by ch_q
   logic [PHASE_W-1:0]    p, a_fold;
   logic [1:0]            ws;
   logic [OUT_W-1:0]      saw_v, sq_v, tri_u, tri_v, tri_o, sine_v, wave_v;
   logic signed [XW-1:0]  y_sum, y_rnd, x_sh, y_sh;

   always_comb begin
      p      = phase_q[ch_q];
      ws     = wsel_q[ch_q];
      a_fold = (p[PHASE_W-1] ^ p[PHASE_W-2]) ? (HALF - p) : p;
      saw_v  = {~p[PHASE_W-1], p[PHASE_W-2 -: OUT_W-1]};
      sq_v   = p[PHASE_W-1] ? NFS_O : FS_O;
      tri_u  = p[PHASE_W-2 -: OUT_W];
      tri_v  = p[PHASE_W-1] ? ~tri_u : tri_u;
      tri_o  = {~tri_v[OUT_W-1], tri_v[OUT_W-2:0]};
      x_sh   = x_q >>> iter_q;
      y_sh   = y_q >>> iter_q;
      y_sum  = y_q + RND_X;
      y_rnd  = y_sum >>> FRAC;
      if (y_rnd > FS_X)
         sine_v = FS_O;
      else if (y_rnd < NFS_X)
         sine_v = NFS_O;
      else
         sine_v = y_rnd[OUT_W-1:0];
      case (ws)
         2'b00:   wave_v = sine_v;
         2'b01:   wave_v = saw_v;
         2'b10:   wave_v = sq_v;
         default: wave_v = tri_o;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         ch_q    <= '0;
         iter_q  <= '0;
         x_q     <= '0;
         y_q     <= '0;
         z_q     <= '0;
         valid_q <= 1'b0;
         busy_q  <= 1'b0;
         for (int c = 0; c < NUM_CH; c++) begin
            phase_q[c]  <= '0;
            delta_q[c]  <= '0;
            wsel_q[c]   <= '0;
            shadow_q[c] <= '0;
            out_q[c]    <= '0;
         end
      end else begin
         valid_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (sample_tick) begin
                  for (int c = 0; c < NUM_CH; c++) begin
                     delta_q[c] <= delta_in[c];
                     wsel_q[c]  <= wsel_in[c];
                  end
                  ch_q    <= '0;
                  busy_q  <= 1'b1;
                  state_q <= S_LOAD;
               end
            end
            S_LOAD: begin
               if (ws == 2'b00) begin
                  x_q     <= X0;
                  y_q     <= '0;
                  z_q     <= $signed(a_fold);
                  iter_q  <= '0;
                  state_q <= S_ROT;
               end else begin
                  state_q <= S_STORE;
               end
            end
            S_ROT: begin
               // Rotate toward z = 0; sign of the residual angle picks the direction
               if (!z_q[PHASE_W-1]) begin
                  x_q <= x_q - y_sh;
                  y_q <= y_q + x_sh;
                  z_q <= z_q - $signed(atan_tab[iter_q]);
               end else begin
                  x_q <= x_q + y_sh;
                  y_q <= y_q - x_sh;
                  z_q <= z_q + $signed(atan_tab[iter_q]);
               end
               if (iter_q == ITW'(CORDIC_ITERS - 1))
                  state_q <= S_STORE;
               else
                  iter_q <= iter_q + ITW'(1);
            end
            S_STORE: begin
               shadow_q[ch_q] <= wave_v;
               phase_q[ch_q]  <= p + delta_q[ch_q];
               if (ch_q == CHW'(NUM_CH - 1)) begin
                  state_q <= S_DONE;
               end else begin
                  ch_q    <= ch_q + CHW'(1);
                  state_q <= S_LOAD;
               end
            end
            S_DONE: begin
               for (int c = 0; c < NUM_CH; c++)
                  out_q[c] <= shadow_q[c];
               valid_q <= 1'b1;
               busy_q  <= 1'b0;
               state_q <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase
`ifdef OSC_BANK_HARD_SYNC_EN
         // Placed last so a sync wins over a same-cycle STORE increment
         for (int c = 0; c < NUM_CH; c++)
            if (phase_sync[c])
               phase_q[c] <= '0;
`endif
      end
   end
endmodule

// File: tb/tb_osc_bank.sv
// Directed, table-driven bench for osc_bank at default parameters (4 ch, 24-bit phase, 16-bit out).
module tb_osc_bank;
   localparam int NUM_CH = 4;
   localparam int PW     = 24;
   localparam int OW     = 16;

   logic                  clk = 1'b0;
   logic                  rst = 1'b1;
   logic                  sample_tick = 1'b0;
   logic [NUM_CH*PW-1:0]  delta_phase = '0;
   logic [NUM_CH*2-1:0]   wave_sel = '0;
`ifdef OSC_BANK_HARD_SYNC_EN
   logic [NUM_CH-1:0]     phase_sync = '0;
`endif
   wire  [NUM_CH*OW-1:0]  ch_sample;
   wire                   sample_valid;
   wire                   busy;

   int n_chk  = 0;
   int n_fail = 0;
   int n_tick = 0;

   osc_bank dut (
      .clk          (clk),
      .rst          (rst),
      .sample_tick  (sample_tick),
      .delta_phase  (delta_phase),
      .wave_sel     (wave_sel),
`ifdef OSC_BANK_HARD_SYNC_EN
      .phase_sync   (phase_sync),
`endif
      .ch_sample    (ch_sample),
      .sample_valid (sample_valid),
      .busy         (busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit         rst;
      logic [7:0] wsel;
      logic [PW-1:0] d0;
      logic [PW-1:0] d1;
      int e0, t0, e1, t1, e3, t3;
      int lat;
   } vec_t;

   vec_t vecs [16];

   task automatic chk(input string name, input int act, input int exp, input int tol);
      n_chk++;
      if (act - exp > tol || exp - act > tol) begin
         n_fail++;
         $display("FAIL %s actual=%0d expected=%0d tol=%0d", name, act, exp, tol);
      end
   endtask

   function automatic int chv(input int c);
      logic signed [OW-1:0] v;
      v = ch_sample[c*OW +: OW];
      return int'(v);
   endfunction

   task automatic set_inputs(input logic [7:0] wsel, input logic [PW-1:0] d0, input logic [PW-1:0] d1);
      wave_sel    = wsel;
      delta_phase = {d0, d0, d1, d0};
   endtask

   task automatic do_reset();
      rst = 1'b1;
      @(posedge clk);
      @(posedge clk);
      #1;
      rst = 1'b0;
      chk("rst_busy", int'(busy), 0, 0);
      chk("rst_valid", int'(sample_valid), 0, 0);
      for (int c = 0; c < NUM_CH; c++)
         chk("rst_sample", chv(c), 0, 0);
   endtask

   // Count edges from the one that samples the tick to the one that raises sample_valid
   task automatic tick_set(output int lat);
      sample_tick = 1'b1;
      lat = 0;
      do begin
         @(posedge clk);
         #1;
         sample_tick = 1'b0;
         lat++;
      end while (!sample_valid && lat < 400);
      if (lat >= 400) begin
         n_chk++;
         n_fail++;
         $display("FAIL tick_timeout actual=no_valid expected=valid_within_400");
      end
      n_tick++;
      $display("tick %0d lat=%0d ch0=%0d ch1=%0d ch2=%0d ch3=%0d",
               n_tick, lat, chv(0), chv(1), chv(2), chv(3));
   endtask

   initial begin
      int lat;
      int pulses;
      int busy_mid;

      vecs[0]  = '{1, 8'h55, 24'h400000, 24'h400000, -32768, 0, -32768, 0, -32768, 0, 10};
      vecs[1]  = '{0, 8'h55, 24'h400000, 24'h400000, -16384, 0, -16384, 0, -16384, 0, 10};
      vecs[2]  = '{0, 8'h55, 24'h400000, 24'h400000,      0, 0,      0, 0,      0, 0, 10};
      vecs[3]  = '{0, 8'h55, 24'h400000, 24'h400000,  16384, 0,  16384, 0,  16384, 0, 10};
      vecs[4]  = '{0, 8'h55, 24'h400000, 24'h400000, -32768, 0, -32768, 0, -32768, 0, 10};
      vecs[5]  = '{1, 8'h00, 24'h400000, 24'h400000,      0, 2,      0, 2,      0, 2, 74};
      vecs[6]  = '{0, 8'h00, 24'h400000, 24'h400000,  32767, 2,  32767, 2,  32767, 2, 74};
      vecs[7]  = '{0, 8'h00, 24'h400000, 24'h400000,      0, 2,      0, 2,      0, 2, 74};
      vecs[8]  = '{0, 8'h00, 24'h400000, 24'h400000, -32767, 2, -32767, 2, -32767, 2, 74};
      vecs[9]  = '{0, 8'h00, 24'h400000, 24'h400000,      0, 2,      0, 2,      0, 2, 74};
      vecs[10] = '{1, 8'h5B, 24'h400000, 24'h800000, -32768, 1,  32767, 0, -32768, 0, 10};
      vecs[11] = '{0, 8'h5B, 24'h400000, 24'h800000,      0, 1, -32767, 0, -16384, 0, 10};
      vecs[12] = '{0, 8'h5B, 24'h400000, 24'h800000,  32767, 1,  32767, 0,      0, 0, 10};
      vecs[13] = '{0, 8'h5B, 24'h400000, 24'h800000,      0, 1, -32767, 0,  16384, 0, 10};
      vecs[14] = '{1, 8'hE4, 24'h400000, 24'h400000,      0, 2, -32768, 0, -32768, 1, 26};
      vecs[15] = '{0, 8'hE4, 24'h400000, 24'h400000,  32767, 2, -16384, 0,      0, 1, 26};

      do_reset();

      for (int i = 0; i < 16; i++) begin
         if (vecs[i].rst)
            do_reset();
         set_inputs(vecs[i].wsel, vecs[i].d0, vecs[i].d1);
         tick_set(lat);
         chk("vec_latency", lat, vecs[i].lat, 0);
         chk("vec_ch0", chv(0), vecs[i].e0, vecs[i].t0);
         chk("vec_ch1", chv(1), vecs[i].e1, vecs[i].t1);
         chk("vec_ch3", chv(3), vecs[i].e3, vecs[i].t3);
         @(posedge clk);
         #1;
         chk("vec_valid_pulse", int'(sample_valid), 0, 0);
      end

      // Tick re-asserted mid-set is dropped; phase advances exactly once
      do_reset();
      set_inputs(8'h00, 24'h400000, 24'h400000);
      sample_tick = 1'b1;
      pulses   = 0;
      busy_mid = 0;
      for (int cyc = 1; cyc <= 150; cyc++) begin
         @(posedge clk);
         #1;
         sample_tick = 1'b0;
         if (sample_valid) pulses++;
         if (cyc == 9) sample_tick = 1'b1;
         if (cyc == 10) busy_mid = int'(busy);
      end
      $display("retick set pulses=%0d ch0=%0d", pulses, chv(0));
      chk("retick_busy", busy_mid, 1, 0);
      chk("retick_pulses", pulses, 1, 0);
      chk("retick_ch0", chv(0), 0, 2);
      tick_set(lat);
      chk("retick_next_lat", lat, 74, 0);
      chk("retick_next_ch0", chv(0), 32767, 2);

      // Reset in the middle of a sine set aborts it and restarts phase from 0
      do_reset();
      set_inputs(8'h00, 24'h200000, 24'h200000);
      tick_set(lat);
      tick_set(lat);
      chk("abort_pre_ch0", chv(0), 23170, 2);
      sample_tick = 1'b1;
      for (int cyc = 1; cyc <= 30; cyc++) begin
         @(posedge clk);
         #1;
         sample_tick = 1'b0;
      end
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      chk("abort_busy", int'(busy), 0, 0);
      chk("abort_valid", int'(sample_valid), 0, 0);
      for (int c = 0; c < NUM_CH; c++)
         chk("abort_sample", chv(c), 0, 0);
      pulses = 0;
      for (int cyc = 0; cyc < 100; cyc++) begin
         @(posedge clk);
         #1;
         if (sample_valid) pulses++;
      end
      chk("abort_no_valid", pulses, 0, 0);
      tick_set(lat);
      chk("abort_restart_lat", lat, 74, 0);
      chk("abort_restart_ch0", chv(0), 0, 2);
      chk("abort_restart_ch2", chv(2), 0, 2);

`ifdef OSC_BANK_HARD_SYNC_EN
      // Hard sync on channel 0 only
      do_reset();
      set_inputs(8'h55, 24'h400000, 24'h400000);
      tick_set(lat);
      tick_set(lat);
      phase_sync = 4'b0001;
      @(posedge clk);
      #1;
      phase_sync = 4'b0000;
      tick_set(lat);
      chk("sync_ch0", chv(0), -32768, 0);
      chk("sync_ch1", chv(1), 0, 0);
      chk("sync_ch3", chv(3), 0, 0);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end
endmodule
